fir_coeff_loader: RTL and testbench

- Writer side of the FIR tap chain's coefficient interface. Accepts a stream of 16-bit coefficients over a valid/ready handshake from the processor-facing register logic.
- Loads the coefficients into a shadow bank, then commits them atomically to the active bank. The active bank drives every tap's coeff_in in parallel.
- Commit happens only on a cycle with no sample enable, so taps never compute a sample with a half-updated coefficient set.

---
 rtl/fir_coeff_loader.sv | 102 ++++++++++
 tb/tb_fir_coeff_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the FIR tap chain: streams coefficients into a shadow
// bank, then commits them to the active bank on a cycle with no sample enable.
module fir_coeff_loader #(
  parameter int N_TAPS = 8,
  parameter int W      = 16,
  parameter int IDX_W  = $clog2(N_TAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                load_abort,
  input  logic                coeff_valid,
  input  logic [W-1:0]        coeff_data,
  output logic                coeff_ready,
  input  logic                sample_en,
  output logic [N_TAPS*W-1:0] coeff_bus,
  output logic                bank_valid,
  output logic                busy,
  output logic                load_done,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [W-1:0]        rd_data
);

  localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                      state;
  logic [CNT_W-1:0]            idx;
  logic [N_TAPS-1:0][W-1:0]    shadow;
  logic [N_TAPS-1:0][W-1:0]    active;

  // Handshake: a beat transfers on any rising edge where coeff_valid and
  // coeff_ready are both high; coeff_valid may drop for any number of cycles.
  assign coeff_ready = (state == LOAD);
  assign busy        = (state != IDLE);
  assign coeff_bus   = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      bank_valid <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        LOAD: begin
          if (load_abort) begin
            state <= IDLE;
            idx   <= '0;
          end else if (coeff_valid) begin
            shadow[idx] <= coeff_data;
            if (idx == LAST) begin
              state <= COMMIT;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        COMMIT: begin
          // Taps must never see a mixed set, so wait for a cycle without a sample.
          if (load_abort) begin
            state <= IDLE;
            idx   <= '0;
          end else if (!sample_en) begin
            active     <= shadow;
            bank_valid <= 1'b1;
            load_done  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      if (rd_idx == IDX_W'(k)) rd_data = active[k];
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: directed and randomized loads checked every cycle
// against a transaction-level model of the shadow/active banks.
module tb_fir_coeff_loader;

  localparam int N_TAPS = 8;
  localparam int W      = 16;
  localparam int IDX_W  = 4;
  localparam int BW     = N_TAPS * W;

  logic                clk;
  logic                rst_n;
  logic                load_start;
  logic                load_abort;
  logic                coeff_valid;
  logic [W-1:0]        coeff_data;
  logic                coeff_ready;
  logic                sample_en;
  logic [BW-1:0]       coeff_bus;
  logic                bank_valid;
  logic                busy;
  logic                load_done;
  logic [IDX_W-1:0]    rd_idx;
  logic [W-1:0]        rd_data;

  fir_coeff_loader #(.N_TAPS(N_TAPS), .W(W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
    .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ready(coeff_ready),
    .sample_en(sample_en), .coeff_bus(coeff_bus), .bank_valid(bank_valid),
    .busy(busy), .load_done(load_done), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 idle, 1 collecting beats, 2 waiting for a quiet cycle
  int            m_mode;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  m_active[N_TAPS];
  logic          m_bank_valid;
  logic          m_done;
  logic [W-1:0]  vals[N_TAPS];

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    exp_q.delete();
    for (int k = 0; k < N_TAPS; k++) m_active[k] = '0;
    m_bank_valid = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [BW-1:0] eb;
    logic [W-1:0]  er;
    for (int k = 0; k < N_TAPS; k++) eb[k*W +: W] = m_active[k];
    er = (int'(rd_idx) < N_TAPS) ? m_active[rd_idx] : '0;
    chk({tag, ".coeff_bus"}, coeff_bus, eb);
    chk({tag, ".rd_data"}, BW'(rd_data), BW'(er));
    chk({tag, ".coeff_ready"}, BW'(coeff_ready), BW'(m_mode == 1));
    chk({tag, ".busy"}, BW'(busy), BW'(m_mode != 0));
    chk({tag, ".bank_valid"}, BW'(bank_valid), BW'(m_bank_valid));
    chk({tag, ".load_done"}, BW'(load_done), BW'(m_done));
  endtask

  // driver: apply inputs, advance one edge, update model, check outputs
  task automatic cyc(input string tag, input logic ls, input logic la, input logic cv,
                     input logic [W-1:0] cd, input logic se, input logic [IDX_W-1:0] ri);
    load_start = ls; load_abort = la; coeff_valid = cv;
    coeff_data = cd; sample_en = se; rd_idx = ri;
    @(posedge clk);
    m_done = 1'b0;
    case (m_mode)
      0: if (ls) begin m_mode = 1; exp_q.delete(); end
      1: if (la) m_mode = 0;
         else if (cv) begin
           exp_q.push_back(cd);
           if (exp_q.size() == N_TAPS) m_mode = 2;
         end
      default: if (la) m_mode = 0;
         else if (!se) begin
           for (int k = 0; k < N_TAPS; k++) m_active[k] = exp_q[k];
           m_bank_valid = 1'b1;
           m_done = 1'b1;
           m_mode = 0;
         end
    endcase
    #1;
    check_all(tag);
  endtask

  function automatic logic [IDX_W-1:0] rnd_idx();
    return IDX_W'($urandom_range(0, 15));
  endfunction

  // gap: 0 back-to-back, 1 toggling valid, 2 random valid
  task automatic run_load(input string tag, input int gap, input int abort_at,
                          input int restart_at, input int se_hold);
    logic v;
    int   c;
    cyc({tag, ".start"}, 1'b1, 1'b0, 1'b0, W'($urandom), 1'b0, rnd_idx());
    c = 0;
    while (m_mode == 1 && c < 64) begin
      if (abort_at >= 0 && exp_q.size() == abort_at) begin
        cyc({tag, ".abort"}, 1'b0, 1'b1, 1'b1, vals[abort_at], 1'b0, rnd_idx());
        break;
      end
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      cyc({tag, ".beat"}, (restart_at >= 0 && exp_q.size() == restart_at), 1'b0, v,
          v ? vals[exp_q.size()] : W'($urandom), 1'($urandom_range(0, 1)), rnd_idx());
      c++;
    end
    if (c >= 64) chk({tag, ".load_timeout"}, BW'(m_mode), BW'(2));
    for (int i = 0; i < se_hold && m_mode == 2; i++)
      cyc({tag, ".hold"}, 1'b0, 1'b0, 1'b0, '0, 1'b1, rnd_idx());
    if (m_mode == 2) cyc({tag, ".commit"}, 1'b0, 1'b0, 1'b0, '0, 1'b0, rnd_idx());
    cyc({tag, ".idle"}, 1'b0, 1'b0, 1'b0, '0, 1'b0, rnd_idx());
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_abort = 1'b0; coeff_valid = 1'b0;
    coeff_data = '0; sample_en = 1'b0; rd_idx = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_all("reset");

    // back-to-back load 1..8
    for (int k = 0; k < N_TAPS; k++) vals[k] = W'(k + 1);
    run_load("b2b", 0, -1, -1, 0);
    cyc("rd3", 1'b0, 1'b0, 1'b0, '0, 1'b0, IDX_W'(3));
    chk("rd3.value", BW'(rd_data), BW'(16'h0004));
    chk("b2b.bank_valid", BW'(bank_valid), BW'(1));

    // toggling valid with corner values
    vals[0] = 16'hFFFF; vals[1] = 16'h8000; vals[2] = 16'h7FFF; vals[3] = 16'h0000;
    vals[4] = 16'h5555; vals[5] = 16'hAAAA; vals[6] = 16'h0001; vals[7] = 16'hFFFE;
    run_load("toggle", 1, -1, -1, 0);
    chk("toggle.tap0", BW'(coeff_bus[W-1:0]), BW'(16'hFFFF));
    chk("toggle.tap7", BW'(coeff_bus[BW-1 -: W]), BW'(16'hFFFE));

    // commit held off by sample_en for 5 cycles
    for (int k = 0; k < N_TAPS; k++) vals[k] = W'($urandom);
    run_load("hold", 0, -1, -1, 5);

    // abort after 4 beats, then a clean full load
    for (int k = 0; k < N_TAPS; k++) vals[k] = W'($urandom);
    run_load("abort", 0, 4, -1, 0);
    for (int k = 0; k < N_TAPS; k++) vals[k] = W'($urandom);
    run_load("after_abort", 2, -1, -1, 0);

    // load_start mid-load must not restart; out-of-range readback
    for (int k = 0; k < N_TAPS; k++) vals[k] = W'($urandom);
    run_load("restart", 0, -1, 3, 0);
    cyc("rd9", 1'b0, 1'b0, 1'b0, '0, 1'b0, IDX_W'(9));
    chk("rd9.value", BW'(rd_data), BW'(0));

    // randomized loads
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < N_TAPS; k++) vals[k] = W'($urandom);
      run_load("rand", 2, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, N_TAPS - 1)) : -1,
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, N_TAPS - 1)) : -1,
               int'($urandom_range(0, 6)));
    end

    // asynchronous reset mid-load after a valid commit
    for (int k = 0; k < N_TAPS; k++) vals[k] = W'($urandom);
    cyc("ar.start", 1'b1, 1'b0, 1'b0, '0, 1'b0, IDX_W'(2));
    for (int k = 0; k < 3; k++)
      cyc("ar.beat", 1'b0, 1'b0, 1'b1, vals[k], 1'b0, IDX_W'(2));
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("ar.async");
    #2 rst_n = 1'b1;
    for (int k = 0; k < N_TAPS; k++) vals[k] = W'($urandom);
    run_load("ar.reload", 0, -1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
